// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states,
// exception codes and datapath widths.
package mem_access_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_BUS      = 2'b10
  } exc_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master)
// and the multi-cycle data memory (slave).
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_access_stage_wait_timer.sv
// WAIT-state watchdog: counts cycles without an acknowledge and flags
// the last permitted cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 8'd1;
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: converts loads/stores into a req/ack transaction,
// stalls upstream while it is outstanding and builds the MEM/WB bundle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_memread,
  input  logic                in_memwrite,
  input  logic                in_regwrite,
  input  logic                in_memtoreg,
  input  logic [DATA_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [REG_W-1:0]    in_rd,
  output logic                stall,
  mem_access_stage_if.master  bus,
  output logic                out_valid,
  output logic                out_regwrite,
  output logic                out_memtoreg,
  output logic [DATA_W-1:0]   out_read_data,
  output logic [DATA_W-1:0]   out_alu,
  output logic [REG_W-1:0]    out_rd,
  output logic [1:0]          out_exc
);

  state_t            state, state_n;
  logic [DATA_W-1:0] rdata_p1;
  exc_t              exc_p1;
  logic              access, misaligned, ack;
  logic              issue, ack_hit, to_hit;
  logic              tmr_clr, tmr_en, tmr_expire;

  assign access     = in_valid & (in_memread | in_memwrite);
  assign misaligned = (in_addr[1:0] != 2'b00);
  // Acknowledges outside an outstanding request are meaningless.
  assign ack        = bus.mem_ack & bus.mem_req;

  assign out_alu      = in_addr;
  assign out_rd       = in_rd;
  assign out_memtoreg = in_memtoreg;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_n       = state;
    stall         = 1'b0;
    out_valid     = 1'b0;
    out_regwrite  = 1'b0;
    out_read_data = '0;
    out_exc       = EXC_NONE;
    issue         = 1'b0;
    ack_hit       = 1'b0;
    to_hit        = 1'b0;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (access && misaligned) begin
          out_valid = 1'b1;
          out_exc   = EXC_MISALIGN;
        end else if (access) begin
          stall   = 1'b1;
          issue   = 1'b1;
          tmr_clr = 1'b1;
          state_n = WAIT;
        end else begin
          out_valid    = in_valid;
          out_regwrite = in_regwrite;
        end
      end
      WAIT: begin
        stall = 1'b1;
        // Ack takes priority over a coincident timeout.
        if (ack) begin
          ack_hit = 1'b1;
          state_n = DONE;
        end else if (tmr_expire) begin
          to_hit  = 1'b1;
          state_n = DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        out_valid     = 1'b1;
        out_read_data = rdata_p1;
        out_exc       = exc_p1;
        out_regwrite  = in_regwrite & (exc_p1 == EXC_NONE);
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request issue / completion boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rdata_p1      <= '0;
      exc_p1        <= EXC_NONE;
    end else begin
      state <= state_n;
      if (issue) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= in_memwrite;
        bus.mem_addr  <= in_addr;
        bus.mem_wdata <= in_wdata;
      end
      if (ack_hit) begin
        bus.mem_req <= 1'b0;
        rdata_p1    <= bus.mem_we ? '0 : bus.mem_rdata;
        exc_p1      <= EXC_NONE;
      end else if (to_hit) begin
        bus.mem_req <= 1'b0;
        rdata_p1    <= '0;
        exc_p1      <= EXC_BUS;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a small memory responder
// and a transaction-level expectation model.
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_memread = 1'b0, in_memwrite = 1'b0;
  logic        in_regwrite = 1'b0, in_memtoreg = 1'b0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        stall, out_valid, out_regwrite, out_memtoreg;
  logic [31:0] out_read_data, out_alu;
  logic [4:0]  out_rd;
  logic [1:0]  out_exc;

  int checks = 0;
  int failures = 0;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .stall(stall), .bus(bus),
    .out_valid(out_valid), .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
    .out_read_data(out_read_data), .out_alu(out_alu), .out_rd(out_rd), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall_cyc;
    int          req_cyc;
    logic        addr_ok, we, valid, rw, m2r, req_after, hung;
    logic [31:0] wdata, rdata, alu;
    logic [1:0]  exc;
    logic [4:0]  rd;
  } obs_t;

  typedef struct {
    int          stall_cyc;
    int          req_cyc;
    logic        rw;
    logic [31:0] rdata;
    logic [1:0]  exc;
  } exp_t;

  // Transaction-level expectation: latency and result from the access rules.
  function automatic exp_t model(bit ld, bit st, logic [31:0] addr, logic [31:0] rdata,
                                 bit rw, int ack_wait);
    exp_t e;
    e.stall_cyc = 0; e.req_cyc = 0; e.rw = rw; e.rdata = 0; e.exc = 2'b00;
    if (ld || st) begin
      if (addr[1:0] != 2'b00) begin
        e.exc = 2'b01; e.rw = 1'b0;
      end else if (ack_wait >= 1 && ack_wait <= T) begin
        e.req_cyc = ack_wait; e.stall_cyc = ack_wait + 1;
        e.rdata = st ? 32'h0 : rdata;
      end else begin
        e.req_cyc = T; e.stall_cyc = T + 1; e.exc = 2'b10; e.rw = 1'b0;
      end
    end
    return e;
  endfunction

  // Presents one instruction, plays the memory, and records what the stage did.
  task automatic run_access(input bit sync, input bit leave, input bit ld, input bit st,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input bit rw, input bit m2r,
                            input logic [4:0] rd, input int ack_wait, output obs_t o);
    int cyc = 0;
    int wcnt = 0;
    if (sync) @(negedge clk);
    in_valid = 1'b1; in_memread = ld; in_memwrite = st; in_addr = addr;
    in_wdata = wdata; in_regwrite = rw; in_memtoreg = m2r; in_rd = rd;
    bus.mem_ack = 1'b0; bus.mem_rdata = rdata;
    if (sync) #1;
    else begin @(posedge clk); #1; end
    o.req_cyc = 0; o.addr_ok = 1'b1; o.we = 1'b0; o.wdata = '0;
    while (stall && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.mem_req) begin
        wcnt++; o.req_cyc++;
        if (bus.mem_addr !== addr) o.addr_ok = 1'b0;
        o.we = bus.mem_we; o.wdata = bus.mem_wdata;
        bus.mem_ack = (wcnt == ack_wait);
      end else begin
        bus.mem_ack = 1'b0;
      end
      #1;
    end
    o.hung = (cyc >= 40); o.stall_cyc = cyc;
    o.valid = out_valid; o.rw = out_regwrite; o.m2r = out_memtoreg;
    o.rdata = out_read_data; o.alu = out_alu; o.rd = out_rd; o.exc = out_exc;
    o.req_after = 1'b0;
    if (cyc == 0) begin
      @(posedge clk); #1;
      o.req_after = bus.mem_req;
      if (!leave) in_valid = 1'b0;
    end else if (!leave) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      o.req_after = bus.mem_req;
    end
  endtask

  task automatic test_reset();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL reset_bus got addr=%h wdata=%h we=%b exp=0", bus.mem_addr, bus.mem_wdata, bus.mem_we); end
    checks++; if (stall !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out got stall=%b valid=%b exp=0,0", stall, out_valid); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_alu();
    obs_t o;
    run_access(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 1, 0, 5'd5, 0, o);
    checks++; if (o.stall_cyc != 0 || o.req_cyc != 0 || o.req_after !== 1'b0) begin
      failures++; $display("FAIL alu_latency got stall=%0d req=%0d req_after=%b exp=0,0,0", o.stall_cyc, o.req_cyc, o.req_after); end
    checks++; if (o.valid !== 1'b1 || o.alu !== 32'h10 || o.rd !== 5'd5 || o.rw !== 1'b1 || o.exc !== 2'b00) begin
      failures++; $display("FAIL alu_bundle got v=%b alu=%h rd=%0d rw=%b exc=%b exp 1,10,5,1,00", o.valid, o.alu, o.rd, o.rw, o.exc); end
  endtask

  task automatic test_load();
    obs_t o;
    run_access(1, 0, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1, 5'd7, 3, o);
    checks++; if (o.hung || o.stall_cyc != 4) begin
      failures++; $display("FAIL load_stall got=%0d hung=%b exp=4", o.stall_cyc, o.hung); end
    checks++; if (o.addr_ok !== 1'b1 || o.we !== 1'b0) begin
      failures++; $display("FAIL load_bus got addr_ok=%b we=%b exp 1,0", o.addr_ok, o.we); end
    checks++; if (o.valid !== 1'b1 || o.rdata !== 32'hDEADBEEF || o.exc !== 2'b00 || o.rw !== 1'b1) begin
      failures++; $display("FAIL load_done got v=%b data=%h exc=%b rw=%b exp 1,deadbeef,00,1", o.valid, o.rdata, o.exc, o.rw); end
  endtask

  task automatic test_store();
    obs_t o;
    run_access(1, 0, 0, 1, 32'h40, 32'h12345678, 32'hFFFF0000, 0, 1, 5'd9, 1, o);
    checks++; if (o.we !== 1'b1 || o.wdata !== 32'h12345678 || o.req_cyc != 1) begin
      failures++; $display("FAIL store_bus got we=%b wdata=%h req=%0d exp 1,12345678,1", o.we, o.wdata, o.req_cyc); end
    checks++; if (o.valid !== 1'b1 || o.exc !== 2'b00 || o.rw !== 1'b0 || o.m2r !== 1'b1 || o.rdata !== 32'h0) begin
      failures++; $display("FAIL store_done got v=%b exc=%b rw=%b m2r=%b data=%h exp 1,00,0,1,0", o.valid, o.exc, o.rw, o.m2r, o.rdata); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_access(1, 0, 1, 0, 32'h102, 32'h0, 32'h0, 1, 1, 5'd3, 1, o);
    checks++; if (o.stall_cyc != 0 || o.req_cyc != 0 || o.req_after !== 1'b0) begin
      failures++; $display("FAIL misalign_req got stall=%0d req=%0d req_after=%b exp 0,0,0", o.stall_cyc, o.req_cyc, o.req_after); end
    checks++; if (o.valid !== 1'b1 || o.exc !== 2'b01 || o.rw !== 1'b0) begin
      failures++; $display("FAIL misalign_out got v=%b exc=%b rw=%b exp 1,01,0", o.valid, o.exc, o.rw); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1, 0, 1, 0, 32'h200, 32'h0, 32'hCAFEF00D, 1, 1, 5'd4, 0, o);
    checks++; if (o.hung || o.req_cyc != T || o.stall_cyc != T + 1) begin
      failures++; $display("FAIL timeout_len got req=%0d stall=%0d exp %0d,%0d", o.req_cyc, o.stall_cyc, T, T + 1); end
    checks++; if (o.exc !== 2'b10 || o.rw !== 1'b0 || o.rdata !== 32'h0 || o.valid !== 1'b1) begin
      failures++; $display("FAIL timeout_done got exc=%b rw=%b data=%h v=%b exp 10,0,0,1", o.exc, o.rw, o.rdata, o.valid); end
    @(negedge clk) bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL stray_ack got req=%b stall=%b v=%b exp 0,0,0", bus.mem_req, stall, out_valid); end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    @(negedge clk);
    in_valid = 1'b1; in_memread = 1'b1; in_memwrite = 1'b0; in_addr = 32'h300;
    in_regwrite = 1'b1; bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mem_req !== 1'b1 || stall !== 1'b1) begin
      failures++; $display("FAIL rstwait_pre got req=%b stall=%b exp 1,1", bus.mem_req, stall); end
    #2 in_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rstwait_async got req=%b stall=%b exp 0,0", bus.mem_req, stall); end
    bus.mem_ack = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rstwait_late_ack got req=%b v=%b exp 0,0", bus.mem_req, out_valid); end
    run_access(1, 0, 0, 0, 32'h44, 32'h0, 32'h0, 1, 0, 5'd11, 0, o);
    checks++; if (o.stall_cyc != 0 || o.valid !== 1'b1 || o.alu !== 32'h44 || o.rd !== 5'd11 || o.req_after !== 1'b0) begin
      failures++; $display("FAIL rstwait_alu got stall=%0d v=%b alu=%h rd=%0d req=%b exp 0,1,44,11,0", o.stall_cyc, o.valid, o.alu, o.rd, o.req_after); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_access(1, 1, 1, 0, 32'h500, 32'h0, 32'h11112222, 1, 1, 5'd1, 2, o1);
    run_access(0, 0, 1, 0, 32'h504, 32'h0, 32'h33334444, 1, 1, 5'd2, 2, o2);
    checks++; if (o1.stall_cyc != 3 || o1.rdata !== 32'h11112222) begin
      failures++; $display("FAIL b2b_first got stall=%0d data=%h exp 3,11112222", o1.stall_cyc, o1.rdata); end
    checks++; if (o2.stall_cyc != 3 || o2.rdata !== 32'h33334444 || o2.addr_ok !== 1'b1) begin
      failures++; $display("FAIL b2b_second got stall=%0d data=%h addr_ok=%b exp 3,33334444,1", o2.stall_cyc, o2.rdata, o2.addr_ok); end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    for (int i = 0; i < 30; i++) begin
      bit ld, st, rw, m2r;
      logic [31:0] addr, wdata, rdata;
      logic [4:0] rd;
      int aw, kind;
      kind = int'($urandom_range(0, 3));
      ld = (kind == 1 || kind == 3); st = (kind == 2 || kind == 3);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      wdata = $urandom; rdata = $urandom;
      rw = 1'($urandom); m2r = 1'($urandom); rd = 5'($urandom);
      aw = int'($urandom_range(1, T + 2));
      e = model(ld, st, addr, rdata, rw, aw);
      run_access(1, 0, ld, st, addr, wdata, rdata, rw, m2r, rd, aw, o);
      checks++; if (o.hung || o.stall_cyc != e.stall_cyc || o.req_cyc != e.req_cyc) begin
        failures++; $display("FAIL rand%0d_timing got stall=%0d req=%0d exp %0d,%0d", i, o.stall_cyc, o.req_cyc, e.stall_cyc, e.req_cyc); end
      checks++; if (o.valid !== 1'b1 || o.exc !== e.exc || o.rw !== e.rw || o.rdata !== e.rdata) begin
        failures++; $display("FAIL rand%0d_result got v=%b exc=%b rw=%b data=%h exp 1,%b,%b,%h", i, o.valid, o.exc, o.rw, o.rdata, e.exc, e.rw, e.rdata); end
      checks++; if (o.alu !== addr || o.rd !== rd || o.m2r !== m2r || o.req_after !== 1'b0) begin
        failures++; $display("FAIL rand%0d_pass got alu=%h rd=%0d m2r=%b req_after=%b exp %h,%0d,%b,0", i, o.alu, o.rd, o.m2r, o.req_after, addr, rd, m2r); end
      if (e.req_cyc > 0) begin
        checks++; if (o.addr_ok !== 1'b1 || o.we !== st || (st && o.wdata !== wdata)) begin
          failures++; $display("FAIL rand%0d_bus got addr_ok=%b we=%b wdata=%h exp 1,%b,%h", i, o.addr_ok, o.we, o.wdata, st, wdata); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage between the EX/MEM register and the MEM/WB register.
- Turns load/store requests into a req/ack handshake with a multi-cycle data memory.
- Stalls upstream stages while an access is in flight, and presents the write-back bundle (control bits, load data, ALU result, rd) to MEM/WB.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles without mem_ack before the access is aborted with a bus error. Legal range 1..255; counter is 8 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  EX/MEM holds a live instruction.
- in_memread  in  1  load.
- in_memwrite  in  1  store.
- in_regwrite  in  1  write-back enable from EX/MEM.
- in_memtoreg  in  1  write-back source select from EX/MEM.
- in_addr  in  32  ALU result / memory address.
- in_wdata  in  32  store data.
- in_rd  in  5  destination register.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  registered word address.
- mem_wdata  out  32  registered store data.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- mem_rdata  in  32  load data, valid with mem_ack.
- out_valid  out  1  bundle valid for MEM/WB this cycle.
- out_regwrite  out  1  write-back enable to MEM/WB.
- out_memtoreg  out  1  write-back source select to MEM/WB.
- out_read_data  out  32  load data.
- out_alu  out  32  pass-through of in_addr.
- out_rd  out  5  destination register.
- out_exc  out  2  00 none, 01 misaligned, 10 bus timeout.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge.
  - State IDLE; mem_req, mem_we, mem_addr, mem_wdata cleared; read latch, exception latch and wait counter cleared.
  - Consequently stall=0 and out_valid=0 while in_valid=0.
  - Reset asserted mid-access drops mem_req immediately; the outstanding access is abandoned and a late mem_ack is ignored.
- Definitions: access = in_valid & (in_memread | in_memwrite); misaligned = in_addr[1:0] != 0.
- State IDLE:
  - No access: combinational pass-through with 0-cycle latency. out_valid=in_valid, out_read_data=0, out_exc=00, stall=0.
  - Access and misaligned: no request issued; stall=0; out_valid=1, out_exc=01, out_regwrite forced 0.
  - Access and aligned: stall=1. On the clock edge, mem_req<=1, mem_we<=in_memwrite, mem_addr<=in_addr, mem_wdata<=in_wdata, counter<=0, state<=WAIT.
  - If in_memread and in_memwrite are both set, treat the instruction as a store.
- State WAIT:
  - stall=1, out_valid=0; mem_req and mem_addr/mem_we/mem_wdata held stable.
  - mem_ack=1: latch mem_rdata (stores latch 0), exc<=00, mem_req<=0, state<=DONE.
  - Otherwise counter increments. When counter==TIMEOUT-1 with no ack: exc<=10, read latch<=0, mem_req<=0, state<=DONE.
  - Ack and timeout in the same cycle: ack wins.
- State DONE: exactly one cycle.
  - stall=0, out_valid=1, out_read_data=latch, out_exc=latched exc.
  - out_regwrite = in_regwrite & (exc==00).
  - state<=IDLE unconditionally. EX/MEM still holds the same instruction in this cycle, so no new access may start from DONE.
- Outputs common to all states: out_alu=in_addr, out_rd=in_rd, out_memtoreg=in_memtoreg.
- Latency:
  - Non-memory instruction: 0 extra cycles.
  - Access: 1 (issue) + N (WAIT, N≥1) + 1 (DONE) cycles.
  - Back-to-back loads incur the full latency each time.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - Exception codes: EXC_NONE=2'b00, EXC_MISALIGN=2'b01, EXC_BUS=2'b10.
  - Word-width and register-index constants, DATA_W=32, REG_W=5.
- Sub-module: mem_wait_timer. Holds the 8-bit counter, with clear/enable inputs and an expire output at TIMEOUT-1.
- FSM and datapath muxing stay in the top-level module.

Test Plan:
- ALU op: in_valid=1, memread=memwrite=0, in_addr=0x0000_0010, rd=5, regwrite=1 -> same cycle stall=0, out_valid=1, out_alu=0x10, out_rd=5, out_regwrite=1, out_exc=00, and mem_req never rises.
- Load with 3-cycle memory: addr=0x0000_0100, ack on the 3rd WAIT cycle with rdata=0xDEAD_BEEF -> stall high for 4 cycles; then one DONE cycle with out_read_data=0xDEADBEEF, out_valid=1; mem_addr stays stable at 0x100 throughout WAIT.
- Store: addr=0x0000_0040, wdata=0x1234_5678, ack after 1 cycle -> mem_we=1, mem_wdata=0x12345678; DONE with out_exc=00; write-back controls follow EX/MEM.
- Misaligned: load at addr=0x0000_0102, regwrite=1 -> no mem_req, stall=0, out_exc=01, out_regwrite=0.
- Timeout: TIMEOUT=4, load with no ack -> mem_req high exactly 4 cycles, then DONE with out_exc=10, out_regwrite=0, out_read_data=0. A subsequent ack pulse while mem_req=0 causes no effect.
- Reset mid-WAIT: assert rst in the 2nd WAIT cycle -> mem_req=0 and stall=0 immediately (asynchronous); after release, state is IDLE and the next ALU op passes through normally.
